dsp48a1_slice: RTL and testbench

Pipelined multiply/accumulate slice modelled on the Spartan-6 DSP48A1 primitive. It contains:
- an 18-bit pre-adder (D±B)
- an 18x18 unsigned multiplier
- 48-bit X/Z operand muxes
- a 48-bit post-adder/subtractor with carry-in/carry-out

Each stage has an optional register, each with its own clock enable and reset. It is the arithmetic datapath leaf used by filter/MAC blocks, with BCOUT and PCOUT provided for cascading.

---
 rtl/dsp48a1_pkg.sv | 28 ++
 rtl/dsp_reg_stage.sv | 31 +++
 rtl/dsp48a1_slice.sv | 140 ++++++++++++++
 tb/tb_dsp48a1_slice.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared widths, OPMODE bit positions and X/Z operand mux encodings
// for the DSP48A1-style multiply/accumulate slice.
package dsp48a1_pkg;

  localparam int PRE_W  = 18;
  localparam int MULT_W = 36;
  localparam int POST_W = 48;

  localparam int OP_POST_SUB = 7;
  localparam int OP_PRE_SUB  = 6;
  localparam int OP_CARRY    = 5;
  localparam int OP_PRE_SEL  = 4;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/dsp_reg_stage.sv
// Optional pipeline register: clocked with CE and async active-high reset
// when REG is nonzero, otherwise a plain wire.
module dsp_reg_stage #(
  parameter int WIDTH = 18,
  parameter int REG   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (REG != 0) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (ce) begin
          q <= d;
        end
      end
    end else begin : g_bypass
      // Control inputs are meaningless in bypass; fold them so they read as used.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/dsp48a1_slice.sv
// Pipelined pre-add / multiply / post-add slice in the style of the Spartan-6
// DSP48A1, with BCOUT and PCOUT available for cascading.
module dsp48a1_slice
  import dsp48a1_pkg::*;
#(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic              CLK,
  input  logic              RSTA,
  input  logic              RSTB,
  input  logic              RSTC,
  input  logic              RSTD,
  input  logic              RSTM,
  input  logic              RSTP,
  input  logic              RSTOPMODE,
  input  logic              RSTCARRYIN,
  input  logic              CEA,
  input  logic              CEB,
  input  logic              CEC,
  input  logic              CED,
  input  logic              CEM,
  input  logic              CEP,
  input  logic              CEOPMODE,
  input  logic              CECARRYIN,
  input  logic [PRE_W-1:0]  A,
  input  logic [PRE_W-1:0]  B,
  input  logic [PRE_W-1:0]  D,
  input  logic [POST_W-1:0] C,
  input  logic [7:0]        OPMODE,
  input  logic [PRE_W-1:0]  BCIN,
  input  logic [POST_W-1:0] PCIN,
  input  logic              CARRYIN,
  output logic [PRE_W-1:0]  BCOUT,
  output logic [POST_W-1:0] PCOUT,
  output logic [POST_W-1:0] P,
  output logic [MULT_W-1:0] M,
  output logic              CARRYOUT,
  output logic              CARRYOUTF
);

  localparam bit USE_BCIN     = (B_INPUT == "CASCADE");
  localparam bit USE_CARRYPIN = (CARRYINSEL == "CARRYIN");

  logic [PRE_W-1:0]  a0_out, a1_out, b_src, b0_out, d_out;
  logic [PRE_W-1:0]  pre_result, b1_in, b1_out;
  logic [7:0]        opmode_out;
  logic [POST_W-1:0] c_out, x_mux, z_mux, p_out;
  logic [MULT_W-1:0] m_in, m_out;
  logic              cyi_in, cyi_out, co_out;
  logic [POST_W:0]   post_sum;
  x_sel_e            x_sel;
  z_sel_e            z_sel;

  assign b_src  = USE_BCIN ? BCIN : B;
  assign cyi_in = USE_CARRYPIN ? CARRYIN : opmode_out[OP_CARRY];

  dsp_reg_stage #(.WIDTH(PRE_W), .REG(A0REG)) u_a0 (
    .clk(CLK), .rst(RSTA), .ce(CEA), .d(A), .q(a0_out));
  dsp_reg_stage #(.WIDTH(PRE_W), .REG(A1REG)) u_a1 (
    .clk(CLK), .rst(RSTA), .ce(CEA), .d(a0_out), .q(a1_out));
  dsp_reg_stage #(.WIDTH(PRE_W), .REG(B0REG)) u_b0 (
    .clk(CLK), .rst(RSTB), .ce(CEB), .d(b_src), .q(b0_out));
  dsp_reg_stage #(.WIDTH(PRE_W), .REG(B1REG)) u_b1 (
    .clk(CLK), .rst(RSTB), .ce(CEB), .d(b1_in), .q(b1_out));
  dsp_reg_stage #(.WIDTH(PRE_W), .REG(DREG)) u_d (
    .clk(CLK), .rst(RSTD), .ce(CED), .d(D), .q(d_out));
  dsp_reg_stage #(.WIDTH(POST_W), .REG(CREG)) u_c (
    .clk(CLK), .rst(RSTC), .ce(CEC), .d(C), .q(c_out));
  dsp_reg_stage #(.WIDTH(8), .REG(OPMODEREG)) u_opmode (
    .clk(CLK), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(opmode_out));
  dsp_reg_stage #(.WIDTH(MULT_W), .REG(MREG)) u_m (
    .clk(CLK), .rst(RSTM), .ce(CEM), .d(m_in), .q(m_out));
  dsp_reg_stage #(.WIDTH(1), .REG(CARRYINREG)) u_cyi (
    .clk(CLK), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cyi_in), .q(cyi_out));
  dsp_reg_stage #(.WIDTH(POST_W), .REG(PREG)) u_p (
    .clk(CLK), .rst(RSTP), .ce(CEP), .d(post_sum[POST_W-1:0]), .q(p_out));
  dsp_reg_stage #(.WIDTH(1), .REG(CARRYOUTREG)) u_cyo (
    .clk(CLK), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(post_sum[POST_W]), .q(co_out));

  // Pre-adder wraps at 18 bits; OPMODE[4] chooses it over the raw B0 value.
  always_comb begin
    pre_result = opmode_out[OP_PRE_SUB] ? (d_out - b0_out) : (d_out + b0_out);
    b1_in      = opmode_out[OP_PRE_SEL] ? pre_result : b0_out;
    m_in       = MULT_W'(b1_out) * MULT_W'(a1_out);
  end

  assign x_sel = x_sel_e'(opmode_out[1:0]);
  assign z_sel = z_sel_e'(opmode_out[3:2]);

  always_comb begin
    x_mux = '0;
    case (x_sel)
      X_ZERO: x_mux = '0;
      X_M:    x_mux = POST_W'(m_out);
      X_P:    x_mux = p_out;
      X_DAB:  x_mux = {d_out[11:0], a1_out, b1_out};
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (z_sel)
      Z_ZERO: z_mux = '0;
      Z_PCIN: z_mux = PCIN;
      Z_P:    z_mux = p_out;
      Z_C:    z_mux = c_out;
      default: z_mux = '0;
    endcase
  end

  // 49-bit post-adder: bit 48 is carry on add and borrow on subtract.
  always_comb begin
    if (opmode_out[OP_POST_SUB]) begin
      post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + (POST_W+1)'(cyi_out));
    end else begin
      post_sum = {1'b0, z_mux} + {1'b0, x_mux} + (POST_W+1)'(cyi_out);
    end
  end

  assign BCOUT     = b1_out;
  assign M         = m_out;
  assign P         = p_out;
  assign PCOUT     = p_out;
  assign CARRYOUT  = co_out;
  assign CARRYOUTF = co_out;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Directed self-checking bench: one default slice plus one configured for
// BCIN cascade input and CARRYIN-port carry selection.
module tb_dsp48a1_slice;

  logic        CLK = 1'b0;
  logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN;
  logic        CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic [7:0]  OPMODE;
  logic        CARRYIN;

  logic [17:0] bcout, bcout2;
  logic [47:0] pcout, p, pcout2, p2;
  logic [35:0] m, m2;
  logic        carryout, carryoutf, carryout2, carryoutf2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dsp48a1_slice dut (
    .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
    .RSTP(RSTP), .RSTOPMODE(RSTOPMODE), .RSTCARRYIN(RSTCARRYIN),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE), .BCIN(BCIN), .PCIN(PCIN),
    .CARRYIN(CARRYIN), .BCOUT(bcout), .PCOUT(pcout), .P(p), .M(m),
    .CARRYOUT(carryout), .CARRYOUTF(carryoutf));

  dsp48a1_slice #(.B_INPUT("CASCADE"), .CARRYINSEL("CARRYIN")) dut_cas (
    .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
    .RSTP(RSTP), .RSTOPMODE(RSTOPMODE), .RSTCARRYIN(RSTCARRYIN),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE), .BCIN(BCIN), .PCIN(PCIN),
    .CARRYIN(CARRYIN), .BCOUT(bcout2), .PCOUT(pcout2), .P(p2), .M(m2),
    .CARRYOUT(carryout2), .CARRYOUTF(carryoutf2));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_rst(input logic v);
    {RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN} = {8{v}};
  endtask

  task automatic set_ce(input logic v);
    {CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN} = {8{v}};
  endtask

  task automatic test_reset();
    A = '0; B = '0; D = '0; C = '0; OPMODE = '0; BCIN = '0; PCIN = '0; CARRYIN = 1'b0;
    set_rst(1'b1);
    set_ce(1'b0);
    tick(2);
    set_rst(1'b0);
    #1;
    checks++; if (p !== 48'd0) begin errors++; $display("[TB] FAIL reset_p got %0h want 0", p); end
    checks++; if (pcout !== 48'd0) begin errors++; $display("[TB] FAIL reset_pcout got %0h want 0", pcout); end
    checks++; if (m !== 36'd0) begin errors++; $display("[TB] FAIL reset_m got %0h want 0", m); end
    checks++; if (bcout !== 18'd0) begin errors++; $display("[TB] FAIL reset_bcout got %0h want 0", bcout); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("[TB] FAIL reset_carryout got %b want 0", carryout); end
    checks++; if (carryoutf !== 1'b0) begin errors++; $display("[TB] FAIL reset_carryoutf got %b want 0", carryoutf); end
    checks++; if (p2 !== 48'd0) begin errors++; $display("[TB] FAIL reset_p2 got %0h want 0", p2); end
  endtask

  task automatic test_latency();
    set_ce(1'b1);
    OPMODE = 8'hFD; A = 18'd2; B = 18'd3; D = 18'd10; C = 48'd100;
    tick(2);
    checks++; if (bcout !== 18'd7) begin errors++; $display("[TB] FAIL lat_bcout got %0d want 7", bcout); end
    tick(1);
    checks++; if (m !== 36'd14) begin errors++; $display("[TB] FAIL lat_m got %0d want 14", m); end
    A = 18'h2A5A5; B = 18'h1F00F; D = 18'h3C3C3; C = 48'h1234_5678_9ABC; OPMODE = 8'h3A;
    tick(1);
    checks++; if (p !== 48'd85) begin errors++; $display("[TB] FAIL lat_p got %0d want 85", p); end
    checks++; if (pcout !== 48'd85) begin errors++; $display("[TB] FAIL lat_pcout got %0d want 85", pcout); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("[TB] FAIL lat_carryout got %b want 0", carryout); end
  endtask

  task automatic test_borrow();
    OPMODE = 8'hFF; D = 18'd1; A = 18'd0; B = 18'd0; C = 48'd0;
    tick(2);
    checks++; if (bcout !== 18'd1) begin errors++; $display("[TB] FAIL dab_bcout got %0d want 1", bcout); end
    tick(1);
    checks++; if (p !== 48'hFFEF_FFFF_FFFE) begin errors++; $display("[TB] FAIL dab_p got %0h want ffeffffffffe", p); end
    checks++; if (carryout !== 1'b1) begin errors++; $display("[TB] FAIL dab_carryout got %b want 1", carryout); end
    checks++; if (carryoutf !== 1'b1) begin errors++; $display("[TB] FAIL dab_carryoutf got %b want 1", carryoutf); end
  endtask

  task automatic test_accumulate();
    RSTP = 1'b1;
    OPMODE = 8'hFE; C = 48'd50;
    tick(2);
    RSTP = 1'b0;
    checks++; if (p !== 48'd0) begin errors++; $display("[TB] FAIL acc_p0 got %0d want 0", p); end
    tick(1);
    checks++; if (p !== 48'd49) begin errors++; $display("[TB] FAIL acc_p1 got %0d want 49", p); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("[TB] FAIL acc_co1 got %b want 0", carryout); end
    tick(1);
    checks++; if (p !== 48'd0) begin errors++; $display("[TB] FAIL acc_p2 got %0d want 0", p); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("[TB] FAIL acc_co2 got %b want 0", carryout); end
    tick(1);
    checks++; if (p !== 48'd49) begin errors++; $display("[TB] FAIL acc_p3 got %0d want 49", p); end
  endtask

  task automatic test_hold_and_async_reset();
    CEP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if (p !== 48'd49) begin errors++; $display("[TB] FAIL hold_p edge %0d got %0d want 49", i, p); end
    end
    #2;
    RSTP = 1'b1;
    #1;
    checks++; if (p !== 48'd0) begin errors++; $display("[TB] FAIL async_rstp got %0d want 0", p); end
    RSTP = 1'b0;
    CEP = 1'b1;
  endtask

  task automatic test_cascade();
    OPMODE = 8'h1D; BCIN = 18'd4; B = 18'd9; D = 18'd1; A = 18'd3; C = 48'd0; CARRYIN = 1'b0;
    tick(4);
    checks++; if (bcout2 !== 18'd5) begin errors++; $display("[TB] FAIL cas_bcout got %0d want 5", bcout2); end
    checks++; if (m2 !== 36'd15) begin errors++; $display("[TB] FAIL cas_m got %0d want 15", m2); end
    checks++; if (p2 !== 48'd15) begin errors++; $display("[TB] FAIL cas_p got %0d want 15", p2); end
    checks++; if (bcout !== 18'd10) begin errors++; $display("[TB] FAIL direct_bcout got %0d want 10", bcout); end
    checks++; if (m !== 36'd30) begin errors++; $display("[TB] FAIL direct_m got %0d want 30", m); end
    checks++; if (p !== 48'd30) begin errors++; $display("[TB] FAIL direct_p got %0d want 30", p); end
    CARRYIN = 1'b1;
    tick(2);
    checks++; if (p2 !== 48'd16) begin errors++; $display("[TB] FAIL cas_carryin_p got %0d want 16", p2); end
    checks++; if (p !== 48'd30) begin errors++; $display("[TB] FAIL direct_ignores_carryin got %0d want 30", p); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_borrow();
    test_accumulate();
    test_hold_and_async_reset();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
